// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial unsigned subtractor, diff = a - b, LSB first, one bit
//            per clock through a single borrow flip-flop.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             w_x, w_y, w_d, w_br_next, w_last;
  logic [WIDTH-1:0] w_res_shift;

  // Full-subtractor cell on the current LSB pair
  assign w_x         = sa_q[0];
  assign w_y         = sb_q[0];
  assign w_d         = w_x ^ w_y ^ borrow_q;
  assign w_br_next   = (~w_x & w_y) | (~(w_x ^ w_y) & borrow_q);
  assign w_res_shift = {w_d, res_q[WIDTH-1:1]};
  assign w_last      = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    bout_d   = bout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d     = a;
          sb_d     = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        res_d    = w_res_shift;
        borrow_d = w_br_next;
        cnt_d    = cnt_q + CW'(1);
        if (w_last) begin
          diff_d  = w_res_shift;
          bout_d  = w_br_next;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    busy = busy_q;
    done = done_q;
    diff = diff_q;
    bout = bout_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Directed and random checks of serial_subtractor at WIDTH 8 and 16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st [2];
  logic [15:0] av [2];
  logic [15:0] bv [2];

  logic        busy8, done8, bout8, busy16, done16, bout16;
  logic [7:0]  diff8;
  logic [15:0] diff16;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0][7:0]), .b(bv[0][7:0]),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1]), .b(bv[1]),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
  );

  // Transaction-level model: an accepted op produces (a-b) mod 2^W and a<b
  // exactly W edges later; nothing else about the datapath is modelled.
  int          c_w [2] = '{8, 16};
  logic        m_busy [2];
  logic        m_done [2];
  logic [15:0] m_diff [2];
  logic        m_bout [2];
  logic [15:0] m_pdiff [2];
  logic        m_pbout [2];
  int          m_left [2];
  int          nops [2];

  function automatic logic [15:0] mask_of(int w);
    return (w == 16) ? 16'hFFFF : 16'h00FF;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_diff[i] <= '0; m_bout[i] <= 1'b0;
        m_left[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_done[i] <= 1'b0;
        if (!m_busy[i]) begin
          if (st[i]) begin
            m_busy[i]  <= 1'b1;
            m_left[i]  <= c_w[i];
            m_pdiff[i] <= (av[i] - bv[i]) & mask_of(c_w[i]);
            m_pbout[i] <= (av[i] & mask_of(c_w[i])) < (bv[i] & mask_of(c_w[i]));
            nops[i]    <= nops[i] + 1;
          end
        end else begin
          m_left[i] <= m_left[i] - 1;
          if (m_left[i] == 1) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
            m_diff[i] <= m_pdiff[i];
            m_bout[i] <= m_pbout[i];
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("busy8",  {31'd0, busy8},  {31'd0, m_busy[0]});
      check("done8",  {31'd0, done8},  {31'd0, m_done[0]});
      check("diff8",  {24'd0, diff8},  {16'd0, m_diff[0]});
      check("bout8",  {31'd0, bout8},  {31'd0, m_bout[0]});
      check("busy16", {31'd0, busy16}, {31'd0, m_busy[1]});
      check("done16", {31'd0, done16}, {31'd0, m_done[1]});
      check("diff16", {16'd0, diff16}, {16'd0, m_diff[1]});
      check("bout16", {31'd0, bout16}, {31'd0, m_bout[1]});
    end
  end

  // One 8-bit op with literal expectations; latency counted in edges after accept.
  task automatic op8(input logic [7:0] a_in, input logic [7:0] b_in,
                     input logic [7:0] exp_d, input logic exp_b, input string tag);
    int cyc;
    @(negedge clk);
    st[0] = 1'b1; av[0] = {8'd0, a_in}; bv[0] = {8'd0, b_in};
    @(negedge clk);
    st[0] = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc - 1, 8);
    check({tag, "_diff"}, {24'd0, diff8}, {24'd0, exp_d});
    check({tag, "_bout"}, {31'd0, bout8}, {31'd0, exp_b});
  endtask

  initial begin
    int ndone;
    int base0, base1;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; av[i] = '0; bv[i] = '0; nops[i] = 0;
    end
    repeat (2) @(negedge clk);
    check("rst_busy8", {31'd0, busy8}, 0);
    check("rst_done8", {31'd0, done8}, 0);
    check("rst_diff8", {24'd0, diff8}, 0);
    check("rst_bout8", {31'd0, bout8}, 0);
    check("rst_busy16", {31'd0, busy16}, 0);
    check("rst_diff16", {16'd0, diff16}, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // T1..T3
    op8(8'd100, 8'd37, 8'd63, 1'b0, "t1");
    op8(8'd5,   8'd9,  8'd252, 1'b1, "t2a");
    op8(8'd0,   8'd1,  8'd255, 1'b1, "t2b");
    op8(8'd255, 8'd255, 8'd0, 1'b0, "t3a");
    op8(8'd0,   8'd0,  8'd0,  1'b0, "t3b");
    op8(8'd255, 8'd0,  8'd255, 1'b0, "t3c");

    // T4: start held 20 clocks; operands scrambled whenever an op is in flight
    ndone = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        check("t4_diff", {24'd0, diff8}, 7);
      end
      st[0] = (k < 20);
      if (m_busy[0]) begin
        av[0] = 16'($urandom_range(0, 255));
        bv[0] = 16'($urandom_range(0, 255));
      end else begin
        av[0] = 16'd10; bv[0] = 16'd3;
      end
    end
    check("t4_ops", ndone, 3);

    // T5: reset four clocks into an op
    @(negedge clk);
    st[0] = 1'b1; av[0] = 16'd200; bv[0] = 16'd1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_busy", {31'd0, busy8}, 0);
    check("t5_done", {31'd0, done8}, 0);
    check("t5_diff", {24'd0, diff8}, 0);
    check("t5_bout", {31'd0, bout8}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("t5_no_done", ndone, 0);
    op8(8'd3, 8'd2, 8'd1, 1'b0, "t5_next");

    // T6: random traffic on both widths, checked each cycle against the model
    base0 = nops[0];
    base1 = nops[1];
    for (int k = 0; k < 40000 && (nops[0] - base0 < 1000 || nops[1] - base1 < 1000); k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        st[i] = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 7))
          0: begin av[i] = '0; bv[i] = mask_of(c_w[i]); end
          1: begin av[i] = mask_of(c_w[i]); bv[i] = mask_of(c_w[i]); end
          default: begin
            av[i] = 16'($urandom) & mask_of(c_w[i]);
            bv[i] = 16'($urandom) & mask_of(c_w[i]);
          end
        endcase
      end
    end
    st[0] = 1'b0; st[1] = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_ops8_reached",  {31'd0, (nops[0] - base0) >= 1000}, 1);
    check("t6_ops16_reached", {31'd0, (nops[1] - base1) >= 1000}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
